// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and arbiter FSM states shared by the ALU slice
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational add/sub/and/or with zero flag; add/sub wrap
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       opcode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);
  // select the operation; carry and borrow fall off the top
  always_comb begin
    result_o = (opcode_i == OP_ADD) ? a_i + b_i :
               (opcode_i == OP_SUB) ? a_i - b_i :
               (opcode_i == OP_AND) ? a_i & b_i : a_i | b_i;
    zero_o = (result_o == '0);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu_core between two req/ack requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       opcode0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       opcode1,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             done_id,
  output logic             busy
);
  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;
  logic             win;
  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .opcode_i (op_q),
    .result_o (alu_res),
    .zero_o   (alu_zero)
  );
  // last_q remembers who was served; on a tie the other requester wins
  always_comb begin
    win       = (req0 && req1) ? ~last_q : req1;
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    result_d  = result_q;
    zero_d    = zero_q;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: if (req0 || req1) begin
        state_d = S_EXEC;
        last_d  = win;
        id_d    = win;
        a_d     = win ? a1 : a0;
        b_d     = win ? b1 : b0;
        op_d    = win ? opcode1 : opcode0;
      end
      S_EXEC: begin
        state_d   = S_DONE;
        result_d  = alu_res;
        zero_d    = alu_zero;
        done_id_d = id_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers; reset drops any in-flight op
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_id_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_id_q <= done_id_d;
    end
  end
  assign ack0    = (state_q == S_EXEC) && !id_q;
  assign ack1    = (state_q == S_EXEC) && id_q;
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);
  assign result  = result_q;
  assign zero    = zero_q;
  assign done_id = done_id_q;
endmodule
